// File: rtl/anim_sequencer.sv
// Per-frame horizontal scroll sequencer driven by vsync rising edges.
// Steps a wrapped x offset forward or back, with start-up and pause handling.
module anim_sequencer #(
  parameter int WRAP     = 400,
  parameter int MIN_STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic [3:0] speed_in,
  input  logic       dir_in,
  input  logic       pause_in,
  output logic       frame_tick,
  output logic [9:0] x_offset,
  output logic       running,
  output logic [7:0] frame_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [10:0] WRAP_W = 11'(WRAP);
  localparam logic [10:0] MIN_W  = 11'(MIN_STEP);

  logic        vsync_q;
  logic [1:0]  state;
  logic [10:0] step;
  logic [10:0] sum;
  logic [10:0] diff;
  logic [10:0] next_off;

  // One extra bit: diff[10] flags a negative result before wrapping.
  always_comb begin
    step = (speed_in == 4'd0) ? MIN_W : {7'd0, speed_in};
    sum  = {1'b0, x_offset} + step;
    diff = {1'b0, x_offset} - step;
    if (dir_in)
      next_off = diff[10] ? diff + WRAP_W : diff;
    else
      next_off = (sum >= WRAP_W) ? sum - WRAP_W : sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      frame_tick  <= 1'b0;
      state       <= IDLE;
      x_offset    <= 10'd0;
      running     <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync & ~vsync_q;
      if (frame_tick) begin
        case (state)
          IDLE: begin
            state   <= RUN;
            running <= 1'b1;
          end
          default: begin
            if (pause_in) begin
              state <= PAUSE;
            end else begin
              state       <= RUN;
              x_offset    <= next_off[9:0];
              frame_count <= frame_count + 8'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_anim_sequencer;

  localparam int WRAP = 400;
  localparam int MINS = 1;

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic [3:0] speed_in;
  logic       dir_in;
  logic       pause_in;
  logic       frame_tick;
  logic [9:0] x_offset;
  logic       running;
  logic [7:0] frame_count;

  anim_sequencer #(.WRAP(WRAP), .MIN_STEP(MINS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vsync(vsync),
    .speed_in(speed_in),
    .dir_in(dir_in),
    .pause_in(pause_in),
    .frame_tick(frame_tick),
    .x_offset(x_offset),
    .running(running),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Reference model: frames counted in plain integers.
  int m_off, m_cnt, s;
  bit m_started, m_tick, m_prev;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev = 0; m_tick = 0; m_started = 0;
      m_off = 0; m_cnt = 0;
    end else begin
      if (m_tick) begin
        if (!m_started) begin
          m_started = 1;
        end else if (!pause_in) begin
          s = (speed_in == 0) ? MINS : int'(speed_in);
          if (dir_in) m_off = (m_off - s + WRAP) % WRAP;
          else        m_off = (m_off + s) % WRAP;
          m_cnt = (m_cnt + 1) % 256;
        end
      end
      m_tick = vsync && !m_prev;
      m_prev = vsync;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_frame_tick", int'(frame_tick), int'(m_tick));
      check("m_x_offset", int'(x_offset), m_off);
      check("m_running", int'(running), int'(m_started));
      check("m_frame_count", int'(frame_count), m_cnt);
    end
  end

  task automatic pulse(input logic [3:0] sp, input logic d, input logic p);
    speed_in = sp; dir_in = d; pause_in = p; vsync = 1'b1;
    repeat (3) @(negedge clk);
    speed_in = 4'($urandom_range(0, 15));
    dir_in   = 1'($urandom_range(0, 1));
    pause_in = 1'($urandom_range(0, 1));
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int ticks;
  int cnt_before;

  initial begin
    rst_n = 1'b0; vsync = 1'b0;
    speed_in = 4'd0; dir_in = 1'b0; pause_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_x", int'(x_offset), 0);
    check("reset_running", int'(running), 0);
    check("reset_count", int'(frame_count), 0);
    check("reset_tick", int'(frame_tick), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start-up
    pulse(4, 0, 0);
    check("start_running", int'(running), 1);
    check("start_x1", int'(x_offset), 0);
    pulse(4, 0, 0);
    check("start_x2", int'(x_offset), 4);
    pulse(4, 0, 0);
    check("start_x3", int'(x_offset), 8);
    check("start_count", int'(frame_count), 2);

    // Forward wrap
    repeat (97) pulse(4, 0, 0);
    check("fwd_pre", int'(x_offset), 396);
    pulse(4, 0, 0);
    check("fwd_wrap0", int'(x_offset), 0);
    pulse(2, 1, 0);
    check("rev_398", int'(x_offset), 398);
    pulse(15, 0, 0);
    check("fwd_wrap13", int'(x_offset), 13);

    // Reverse wrap and zero speed
    pulse(11, 1, 0);
    check("rev_pre", int'(x_offset), 2);
    pulse(5, 1, 0);
    check("rev_wrap", int'(x_offset), 397);
    pulse(0, 1, 0);
    check("zero_speed", int'(x_offset), 396);

    // Pause
    pulse(15, 0, 0);
    pulse(15, 0, 0);
    pulse(14, 0, 0);
    check("pause_pre", int'(x_offset), 40);
    cnt_before = int'(frame_count);
    pulse(9, 0, 1);
    pulse(9, 1, 1);
    check("pause_x", int'(x_offset), 40);
    check("pause_count", int'(frame_count), cnt_before);
    pulse(3, 0, 0);
    check("resume_x", int'(x_offset), 43);
    check("resume_count", int'(frame_count), (cnt_before + 1) % 256);

    // Long vsync high: one tick only, speed changes ignored
    speed_in = 4'd2; dir_in = 1'b0; pause_in = 1'b0; vsync = 1'b1;
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_tick) ticks++;
      if (i >= 3) speed_in = 4'($urandom_range(0, 15));
    end
    check("hold_ticks", ticks, 1);
    check("hold_x", int'(x_offset), 45);
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // Reset coincident with frame_tick
    repeat (5) pulse(15, 0, 0);
    check("midrun_pre", int'(x_offset), 120);
    speed_in = 4'd5; dir_in = 1'b0; pause_in = 1'b0; vsync = 1'b1;
    @(negedge clk);
    check("midrun_tick", int'(frame_tick), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_x", int'(x_offset), 0);
    check("midrun_running", int'(running), 0);
    check("midrun_count", int'(frame_count), 0);

    // vsync already high at reset release gives one tick into RUN
    rst_n = 1'b1;
    ticks = 0;
    repeat (6) begin
      @(negedge clk);
      if (frame_tick) ticks++;
    end
    check("release_ticks", ticks, 1);
    check("release_running", int'(running), 1);
    check("release_x", int'(x_offset), 0);
    vsync = 1'b0;
    @(negedge clk);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) vsync = ~vsync;
      speed_in = 4'($urandom_range(0, 15));
      dir_in   = 1'($urandom_range(0, 1));
      pause_in = ($urandom_range(0, 4) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anim_sequencer.md
ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 Parameter WRAP, default 400: modulus of the scroll offset; x_offset is always in 0..WRAP-1.
REQ-002 Parameter MIN_STEP, default 1: step used when speed_in samples as 0.
REQ-003 clk  input  1  pixel clock; the only clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 vsync  input  1  vertical sync level from the sync generator, already in the clk domain, active-high.
REQ-006 speed_in  input  4  requested scroll step in pixels per frame.
REQ-007 dir_in  input  1  scroll direction: 0 forward (offset increases), 1 reverse (offset decreases).
REQ-008 pause_in  input  1  1 freezes the scroll.
REQ-009 frame_tick  output  1  one-cycle pulse per frame.
REQ-010 x_offset  output  10  scroll offset consumed by the scene and player logic.
REQ-011 running  output  1  high once the animation has started; gates the player sprite.
REQ-012 frame_count  output  8  number of offset steps applied, modulo 256.

Function
REQ-013 The block shall keep a one-cycle registered copy of vsync (vsync_q) and detect a rising edge as vsync=1 and vsync_q=0.
REQ-014 frame_tick shall be a registered pulse, high for exactly one cycle, in the cycle after the rising edge is detected.
REQ-015 vsync held high for any number of cycles shall produce exactly one frame_tick.
REQ-016 FSM states: IDLE, RUN, PAUSE; all transitions occur only at the clock edge that ends a frame_tick cycle ("tick edge").
REQ-017 In IDLE, at a tick edge the FSM shall go to RUN and set running=1; x_offset shall not change on that edge.
REQ-018 In RUN or PAUSE, at a tick edge with pause_in=1, the FSM shall go to PAUSE with no step applied.
REQ-019 In RUN or PAUSE, at a tick edge with pause_in=0, the FSM shall go to RUN and apply one step.
REQ-020 Step size s: speed_in sampled at the tick edge; s=MIN_STEP when speed_in=0.
REQ-021 Direction: dir_in sampled at the same tick edge; no separate direction register.
REQ-022 Forward step: x_offset <= x_offset+s, minus WRAP when the sum is >= WRAP.
REQ-023 Reverse step: x_offset <= x_offset-s, plus WRAP when the difference is negative.
REQ-024 Arithmetic shall be at least 11 bits wide so that no intermediate overflows; no modulo/divider is used.
REQ-025 frame_count shall increment by 1, wrapping 255->0, on every tick edge that applies a step, and at no other time.
REQ-026 Outside tick edges, x_offset, running, frame_count and the FSM state shall hold their values.
REQ-027 Once set, running shall stay 1 in both RUN and PAUSE, and shall be cleared only by reset.
REQ-028 speed_in, dir_in and pause_in shall be ignored except at tick edges.

Reset
REQ-029 When rst_n=0 at a clock edge, the block shall set: state IDLE, x_offset 0, running 0, frame_count 0, frame_tick 0, vsync_q 0.
REQ-030 Reset shall take priority over a coincident tick edge.
REQ-031 A vsync that is already high when rst_n deasserts shall produce one frame_tick, because vsync_q resets to 0.
REQ-032 Reset asserted mid-operation shall return the block to IDLE from any state.

Verification
REQ-033 Start-up: reset, then 3 vsync pulses with speed_in=4, dir_in=0, pause_in=0 -> running=1 after pulse 1; x_offset 0, 4, 8 after pulses 1, 2, 3; frame_count=2.
REQ-034 Forward wrap: x_offset=396, speed_in=4, dir_in=0, one tick -> x_offset=0. Second case: x_offset=398, speed_in=15 -> x_offset=13.
REQ-035 Reverse wrap and zero speed: x_offset=2, dir_in=1, speed_in=5 -> x_offset=397. Then speed_in=0 -> x_offset=396.
REQ-036 Pause: in RUN at x_offset=40, two ticks with pause_in=1 -> x_offset=40, frame_count unchanged. Next tick with pause_in=0, speed_in=3 -> x_offset=43, state RUN.
REQ-037 Edge detect: vsync held high for 1000 cycles -> exactly one frame_tick, one cycle wide. Changing speed_in between ticks has no effect on x_offset.
REQ-038 Reset mid-run: rst_n=0 in the same cycle as frame_tick, with x_offset=120 -> next cycle x_offset=0, running=0, frame_count=0, state IDLE.
